// File: rtl/char_buffer_eraser_if.sv
// -----------------------------------------------------------------------------
// char_buffer_eraser_if
//
// Bundles the signals between the VT52 command decoder, the character buffer
// and the bulk-edit engine (char_buffer_eraser).
//
//   Command side : cmd_valid, cmd[1:0], cur_row[4:0], cur_col[6:0]  (to engine)
//                  cmd_ready, busy, done                            (from engine)
//   Buffer side  : rd_own, raddr, waddr, din, wen                   (from engine)
//                  rdata (registered RAM read data)                 (to engine)
//
// Modports:
//   slave  - the engine itself
//   master - the environment (decoder + character buffer)
// -----------------------------------------------------------------------------
interface char_buffer_eraser_if #(
   parameter int ADDR_BITS = 11
);
   logic                 cmd_valid;
   logic [1:0]           cmd;
   logic [4:0]           cur_row;
   logic [6:0]           cur_col;
   logic                 cmd_ready;
   logic                 busy;
   logic                 done;
   logic                 rd_own;
   logic [ADDR_BITS-1:0] raddr;
   logic [7:0]           rdata;
   logic [ADDR_BITS-1:0] waddr;
   logic [7:0]           din;
   logic                 wen;

   modport slave (
      input  cmd_valid, cmd, cur_row, cur_col, rdata,
      output cmd_ready, busy, done, rd_own, raddr, waddr, din, wen
   );

   modport master (
      output cmd_valid, cmd, cur_row, cur_col, rdata,
      input  cmd_ready, busy, done, rd_own, raddr, waddr, din, wen
   );
endinterface

// File: rtl/char_buffer_eraser.sv
// -----------------------------------------------------------------------------
// char_buffer_eraser
//
// Bulk-edit engine in front of the COLS x ROWS character buffer. Performs the
// multi-cycle VT52 screen operations one command at a time:
//   cmd 0 : clear from cursor to end of screen
//   cmd 1 : clear from cursor to end of line
//   cmd 2 : scroll up one line (copy rows 1..ROWS-1 up, blank the last row)
//   cmd 3 : clear whole screen
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high; aborts any operation without a done
//   bus    - char_buffer_eraser_if.slave (command handshake + buffer ports)
//
// Build option:
//   CHAR_BUFFER_SCROLL_EN - when defined, cmd 2 performs the scroll. When
//   undefined the copy/fill datapath is absent, rd_own/raddr are tied low and
//   cmd 2 completes immediately without writing.
// -----------------------------------------------------------------------------
module char_buffer_eraser #(
   parameter int         COLS      = 80,
   parameter int         ROWS      = 24,
   parameter int         ADDR_BITS = 11,
   parameter logic [7:0] BLANK     = 8'h20
) (
   input  logic                 clk,
   input  logic                 reset,
   char_buffer_eraser_if.slave  bus
);
   // Internal addresses carry one spare bit so cursor arithmetic on
   // out-of-range rows cannot wrap into a valid-looking address.
   localparam int                 PW      = ADDR_BITS + 1;
   localparam logic [ADDR_BITS:0] COLS_W  = PW'(COLS);
   localparam logic [ADDR_BITS:0] COLS_M1 = PW'(COLS - 1);
   localparam logic [ADDR_BITS:0] LAST_W  = PW'(COLS * ROWS - 1);
   localparam logic [ADDR_BITS:0] ONE_W   = PW'(1);
`ifdef CHAR_BUFFER_SCROLL_EN
   // Last copy step index; also the first address of the bottom row.
   localparam logic [ADDR_BITS:0] COPY_W  = PW'(COLS * (ROWS - 1));
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
`ifdef CHAR_BUFFER_SCROLL_EN
      S_COPY  = 3'd2,
      S_FILL  = 3'd3,
`endif
      S_DONE  = 3'd4
   } state_t;

   state_t               state_reg, state_next;
   logic [ADDR_BITS:0]   ptr_reg, ptr_next;     // write address (CLEAR/FILL) or copy step k (COPY)
   logic [ADDR_BITS:0]   last_reg, last_next;   // inclusive end address of a CLEAR

   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic                 wen_reg, wen_next;
   logic [ADDR_BITS-1:0] waddr_reg, waddr_next;
   logic [7:0]           din_reg, din_next;
`ifdef CHAR_BUFFER_SCROLL_EN
   logic                 rd_own_reg, rd_own_next;
   logic [ADDR_BITS-1:0] raddr_reg, raddr_next;
   logic                 copy_wr_reg, copy_wr_next;
`endif

   // Cursor decode
   logic [ADDR_BITS:0]   row_base_w, start_w, row_last_w;
   logic                 out_of_range;

   always_comb begin
      row_base_w   = PW'(bus.cur_row) * COLS_W;
      start_w      = row_base_w + PW'(bus.cur_col);
      row_last_w   = row_base_w + COLS_M1;
      out_of_range = (bus.cur_row >= 5'(ROWS)) || (bus.cur_col >= 7'(COLS));
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         ptr_reg     <= '0;
         last_reg    <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         wen_reg     <= 1'b0;
         waddr_reg   <= '0;
         din_reg     <= '0;
`ifdef CHAR_BUFFER_SCROLL_EN
         rd_own_reg  <= 1'b0;
         raddr_reg   <= '0;
         copy_wr_reg <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         last_reg    <= last_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         wen_reg     <= wen_next;
         waddr_reg   <= waddr_next;
         din_reg     <= din_next;
`ifdef CHAR_BUFFER_SCROLL_EN
         rd_own_reg  <= rd_own_next;
         raddr_reg   <= raddr_next;
         copy_wr_reg <= copy_wr_next;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      last_next  = last_reg;
      case (state_reg)
         // busy is low in both IDLE and DONE, so a command is accepted in either.
         S_IDLE, S_DONE: begin
            state_next = S_IDLE;
            if (bus.cmd_valid) begin
               if (bus.cmd == 2'd3) begin
                  state_next = S_CLEAR;
                  ptr_next   = '0;
                  last_next  = LAST_W;
               end else if (out_of_range) begin
                  state_next = S_DONE;
               end else begin
                  case (bus.cmd)
                     2'd0: begin
                        state_next = S_CLEAR;
                        ptr_next   = start_w;
                        last_next  = LAST_W;
                     end
                     2'd1: begin
                        state_next = S_CLEAR;
                        ptr_next   = start_w;
                        last_next  = row_last_w;
                     end
                     default: begin
`ifdef CHAR_BUFFER_SCROLL_EN
                        state_next = S_COPY;
                        ptr_next   = '0;
`else
                        state_next = S_DONE;
`endif
                     end
                  endcase
               end
            end
         end
         S_CLEAR: begin
            if (ptr_reg == last_reg) state_next = S_DONE;
            else                     ptr_next   = ptr_reg + ONE_W;
         end
`ifdef CHAR_BUFFER_SCROLL_EN
         // The last copy step only drains the read pipeline; its index equals
         // the first bottom-row address, so FILL continues from ptr as-is.
         S_COPY: begin
            if (ptr_reg == COPY_W) state_next = S_FILL;
            else                   ptr_next   = ptr_reg + ONE_W;
         end
         S_FILL: begin
            if (ptr_reg == LAST_W) state_next = S_DONE;
            else                   ptr_next   = ptr_reg + ONE_W;
         end
`endif
         default: state_next = S_IDLE;
      endcase
   end

   // Output logic: values for the next cycle, registered above
   always_comb begin
      busy_next    = 1'b0;
      done_next    = 1'b0;
      wen_next     = 1'b0;
      waddr_next   = '0;
      din_next     = '0;
`ifdef CHAR_BUFFER_SCROLL_EN
      rd_own_next  = 1'b0;
      raddr_next   = '0;
      copy_wr_next = 1'b0;
`endif
      case (state_next)
         S_CLEAR: begin
            busy_next  = 1'b1;
            wen_next   = 1'b1;
            waddr_next = ADDR_BITS'(ptr_next);
            din_next   = BLANK;
         end
`ifdef CHAR_BUFFER_SCROLL_EN
         // Step k reads row-below address COLS+k and writes k-1 with the data
         // returned for the previous step's read.
         S_COPY: begin
            busy_next    = 1'b1;
            rd_own_next  = 1'b1;
            raddr_next   = ADDR_BITS'(ptr_next + COLS_W);
            copy_wr_next = (ptr_next != '0);
            wen_next     = copy_wr_next;
            waddr_next   = ADDR_BITS'(ptr_next - ONE_W);
         end
         S_FILL: begin
            busy_next  = 1'b1;
            wen_next   = 1'b1;
            waddr_next = ADDR_BITS'(ptr_next);
            din_next   = BLANK;
         end
`endif
         S_DONE:  done_next = 1'b1;
         default: ;
      endcase
   end

   assign bus.busy      = busy_reg;
   assign bus.cmd_ready = !busy_reg;
   assign bus.done      = done_reg;
   assign bus.wen       = wen_reg;
   assign bus.waddr     = waddr_reg;
`ifdef CHAR_BUFFER_SCROLL_EN
   assign bus.rd_own    = rd_own_reg;
   assign bus.raddr     = raddr_reg;
   // Copy data goes straight from the RAM read port to the write port: the
   // RAM output register already provides the pipeline stage.
   assign bus.din       = copy_wr_reg ? bus.rdata : din_reg;
`else
   logic unused_rdata;
   assign unused_rdata  = ^bus.rdata;
   assign bus.rd_own    = 1'b0;
   assign bus.raddr     = '0;
   assign bus.din       = din_reg;
`endif
endmodule

// File: tb/tb_char_buffer_eraser.sv
`timescale 1ns/1ps
module tb_char_buffer_eraser;
   localparam int AB = 11;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   acc_cyc = 0;

   char_buffer_eraser_if #(.ADDR_BITS(AB)) bus();

   char_buffer_eraser #(
      .COLS(80), .ROWS(24), .ADDR_BITS(AB), .BLANK(8'h20)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Character buffer model: registered read, one write port
   logic [7:0] mem [0:1919];
   logic       preload = 1'b0;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1920; i++) mem[i] <= 8'(i);
      end else if (bus.wen === 1'b1 && int'(bus.waddr) < 1920) begin
         mem[bus.waddr] <= bus.din;
      end
      bus.rdata <= (int'(bus.raddr) < 1920) ? mem[bus.raddr] : 8'h00;
   end

   // Monitor, sampled on the falling edge
   int wr_addr[$];
   int wr_data[$];
   int wr_cyc[$];
   int rd_own_cnt = 0;
   int done_cnt = 0;
   always @(negedge clk) begin
      if (bus.wen === 1'b1) begin
         wr_addr.push_back(int'(bus.waddr));
         wr_data.push_back(int'(bus.din));
         wr_cyc.push_back(cyc);
      end
      if (bus.rd_own === 1'b1) rd_own_cnt++;
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      rd_own_cnt = 0;
      done_cnt = 0;
   endtask

   // Presents a command for exactly one cycle; acc_cyc is the accept cycle A.
   task automatic issue(input logic [1:0] c, input logic [4:0] r, input logic [6:0] col);
      @(posedge clk);
      clear_log();
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd       = c;
      bus.cur_row   = r;
      bus.cur_col   = col;
      acc_cyc       = cyc;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   // Returns the cycle in which done was seen, or -1 when the budget runs out.
   task automatic wait_done(input int budget, output int dc);
      dc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            dc = cyc;
            break;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd = 2'd0;
      bus.cur_row = '0;
      bus.cur_col = '0;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", bus.wen); end
      checks++; if (bus.rd_own !== 1'b0) begin errors++; $display("FAIL reset_rd_own got=%b exp=0", bus.rd_own); end
      checks++; if (bus.raddr !== 11'd0) begin errors++; $display("FAIL reset_raddr got=%0d exp=0", bus.raddr); end
      checks++; if (bus.waddr !== 11'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", bus.waddr); end
      checks++; if (bus.din !== 8'h00) begin errors++; $display("FAIL reset_din got=%h exp=00", bus.din); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   // cmd 3 ignores the cursor, even an out-of-range one
   task automatic test_clear_screen(input logic [4:0] r);
      int dc, bad;
      issue(2'd3, r, 7'd0);
      wait_done(2500, dc);
      checks++; if (dc !== acc_cyc + 1921) begin errors++; $display("FAIL cls_done_cycle row=%0d got=%0d exp=%0d", r, dc - acc_cyc, 1921); end
      checks++; if (wr_addr.size() !== 1920) begin errors++; $display("FAIL cls_write_count row=%0d got=%0d exp=1920", r, wr_addr.size()); end
      bad = 0;
      foreach (wr_addr[i])
         if (wr_addr[i] != i || wr_data[i] != 32'h20 || wr_cyc[i] != acc_cyc + 1 + i) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL cls_write_seq row=%0d bad=%0d exp=0", r, bad); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL cls_done_count got=%0d exp=1", done_cnt); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL cls_after busy=%b done=%b exp=0/0", bus.busy, bus.done); end
   endtask

   // Partial clears and out-of-range cursors
   task automatic test_clear_ranges();
      int t_cmd[7]   = '{1, 0, 0, 1, 0, 1, 1};
      int t_row[7]   = '{2, 23, 23, 0, 24, 0, 23};
      int t_col[7]   = '{75, 79, 0, 0, 0, 80, 79};
      int t_first[7] = '{235, 1919, 1840, 0, 0, 0, 1919};
      int t_n[7]     = '{5, 1, 80, 80, 0, 0, 1};
      int dc, bad;
      for (int t = 0; t < 7; t++) begin
         issue(2'(t_cmd[t]), 5'(t_row[t]), 7'(t_col[t]));
         wait_done(200, dc);
         checks++; if (dc !== acc_cyc + t_n[t] + 1) begin errors++; $display("FAIL range%0d_done_cycle got=%0d exp=%0d", t, dc - acc_cyc, t_n[t] + 1); end
         checks++; if (wr_addr.size() !== t_n[t]) begin errors++; $display("FAIL range%0d_write_count got=%0d exp=%0d", t, wr_addr.size(), t_n[t]); end
         bad = 0;
         foreach (wr_addr[i])
            if (wr_addr[i] != t_first[t] + i || wr_data[i] != 32'h20 || wr_cyc[i] != acc_cyc + 1 + i) bad++;
         checks++; if (bad !== 0) begin errors++; $display("FAIL range%0d_write_seq bad=%0d exp=0", t, bad); end
      end
   endtask

   task automatic test_scroll();
      int dc, bad;
      @(negedge clk);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      issue(2'd2, 5'd0, 7'd0);
`ifdef CHAR_BUFFER_SCROLL_EN
      wait_done(2500, dc);
      checks++; if (dc !== acc_cyc + 1922) begin errors++; $display("FAIL scroll_done_cycle got=%0d exp=1922", dc - acc_cyc); end
      checks++; if (rd_own_cnt !== 1841) begin errors++; $display("FAIL scroll_rd_own_cycles got=%0d exp=1841", rd_own_cnt); end
      checks++; if (wr_addr.size() !== 1920) begin errors++; $display("FAIL scroll_write_count got=%0d exp=1920", wr_addr.size()); end
      checks++; if (wr_cyc.size() > 0 && wr_cyc[0] !== acc_cyc + 2) begin errors++; $display("FAIL scroll_first_write got=%0d exp=2", wr_cyc[0] - acc_cyc); end
      bad = 0;
      for (int i = 0; i < 1920; i++)
         if (mem[i] !== ((i < 1840) ? 8'(i + 80) : 8'h20)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL scroll_buffer bad=%0d exp=0", bad); end
`else
      wait_done(50, dc);
      checks++; if (dc !== acc_cyc + 1) begin errors++; $display("FAIL scroll_off_done_cycle got=%0d exp=1", dc - acc_cyc); end
      checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL scroll_off_write_count got=%0d exp=0", wr_addr.size()); end
      checks++; if (rd_own_cnt !== 0) begin errors++; $display("FAIL scroll_off_rd_own got=%0d exp=0", rd_own_cnt); end
      bad = 0;
      for (int i = 0; i < 1920; i++)
         if (mem[i] !== 8'(i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL scroll_off_buffer bad=%0d exp=0", bad); end
`endif
   endtask

   task automatic test_reset_abort();
      int dc;
      issue(2'd3, 5'd0, 7'd0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (wr_addr.size() >= 100) break;
      end
      checks++; if (wr_addr.size() !== 100 || wr_addr[99] !== 99) begin errors++; $display("FAIL abort_reach_write got=%0d exp=100", wr_addr.size()); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.wen !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_outputs wen=%b busy=%b exp=0/0", bus.wen, bus.busy); end
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
      checks++; if (wr_addr.size() !== 100) begin errors++; $display("FAIL abort_write_count got=%0d exp=100", wr_addr.size()); end
      issue(2'd1, 5'd0, 7'd78);
      wait_done(50, dc);
      checks++; if (dc !== acc_cyc + 3) begin errors++; $display("FAIL abort_next_done got=%0d exp=3", dc - acc_cyc); end
      checks++; if (wr_addr.size() !== 2 || wr_addr[0] !== 78 || wr_addr[1] !== 79) begin errors++; $display("FAIL abort_next_writes count=%0d exp=2 (78,79)", wr_addr.size()); end
   endtask

   task automatic test_busy_ignore();
      int dc, bad;
      issue(2'd1, 5'd1, 7'd0);
      repeat (5) @(negedge clk);
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_cmd_ready got=%b exp=0", bus.cmd_ready); end
      bus.cmd_valid = 1'b1;
      bus.cmd = 2'd3;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_done(200, dc);
      checks++; if (dc !== acc_cyc + 81) begin errors++; $display("FAIL busy_done_cycle got=%0d exp=81", dc - acc_cyc); end
      repeat (4) @(negedge clk);
      #1;
      checks++; if (wr_addr.size() !== 80) begin errors++; $display("FAIL busy_write_count got=%0d exp=80", wr_addr.size()); end
      bad = 0;
      foreach (wr_addr[i]) if (wr_addr[i] != 80 + i) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL busy_write_addr bad=%0d exp=0", bad); end
      checks++; if (done_cnt !== 1 || bus.busy !== 1'b0) begin errors++; $display("FAIL busy_not_queued done=%0d busy=%b exp=1/0", done_cnt, bus.busy); end
   endtask

   task automatic test_back_to_back();
      int dc, acc2;
      issue(2'd1, 5'd0, 7'd77);
      wait_done(50, dc);
      checks++; if (dc !== acc_cyc + 4) begin errors++; $display("FAIL b2b_first_done got=%0d exp=4", dc - acc_cyc); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got=%b exp=1", bus.cmd_ready); end
      clear_log();
      bus.cmd_valid = 1'b1;
      bus.cmd = 2'd1;
      bus.cur_row = 5'd1;
      bus.cur_col = 7'd78;
      acc2 = cyc;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b1 || bus.wen !== 1'b1 || bus.waddr !== 11'd158) begin errors++; $display("FAIL b2b_accept busy=%b wen=%b waddr=%0d exp=1/1/158", bus.busy, bus.wen, bus.waddr); end
      wait_done(50, dc);
      checks++; if (dc !== acc2 + 3) begin errors++; $display("FAIL b2b_second_done got=%0d exp=3", dc - acc2); end
      checks++; if (wr_addr.size() !== 2 || wr_addr[0] !== 158 || wr_addr[1] !== 159) begin errors++; $display("FAIL b2b_writes count=%0d exp=2 (158,159)", wr_addr.size()); end
   endtask

   initial begin
      test_reset();
      test_clear_screen(5'd0);
      test_clear_screen(5'd30);
      test_clear_ranges();
      test_scroll();
      test_reset_abort();
      test_busy_ignore();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
